// File: rtl/delay_meas_pkg.sv
// Shared types and constants for the delay-line measurement stages.
package delay_meas_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned GATE_W  = 24;
  localparam int unsigned READ_W  = 24;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam logic [1:0] SEL_LO     = 2'd0;
  localparam logic [1:0] SEL_MID    = 2'd1;
  localparam logic [1:0] SEL_HI     = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  // Status byte layout, MSB first: ovf, busy, state, reserved zeros.
  typedef struct packed {
    logic       ovf;
    logic       busy;
    state_e     state;
    logic [3:0] rsvd;
  } status_t;

  function automatic status_t pack_status(input logic ovf, input logic busy, input state_e st);
    status_t s;
    s.ovf   = ovf;
    s.busy  = busy;
    s.state = st;
    s.rsvd  = 4'b0000;
    return s;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus history flop; rise pulses for one clk per synchronised 0->1.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= d_async;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign rise = sync_q & ~hist_q;

endmodule

// File: rtl/ring_osc_freq_counter.sv
// Counts delay-line oscillator edges over a fixed clk gate window and exposes the latched
// count byte-wise. rst_n release is expected to be synchronised to clk upstream.
module ring_osc_freq_counter
  import delay_meas_pkg::*;
#(
  parameter logic [GATE_W-1:0] GATE_CYCLES = 24'd10_000_000,
  parameter int unsigned       CNT_W       = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              osc_in,
  input  logic              start,
  input  logic [1:0]        sel,
  output logic [BYTE_W-1:0] result_byte,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  state_e             state_q, state_d;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               ovf_next_q, ovf_next_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_q;
  logic               start_rise_c;
  logic               osc_rise_c;
  logic [READ_W-1:0]  res_ext_c;
  status_t            status_c;

  sync_edge_detect u_osc_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (osc_in),
    .rise    (osc_rise_c)
  );

  assign start_rise_c = start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      result_q   <= '0;
      ovf_next_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      result_q   <= result_d;
      ovf_next_q <= ovf_next_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      start_q    <= start;
    end
  end

  // done_q rises together with the new result so a reader sampling on done sees fresh data.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    result_d   = result_q;
    ovf_next_d = ovf_next_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    if (!ena) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_rise_c) begin
            state_d    = ST_GATE;
            gate_cnt_d = GATE_CYCLES - GATE_W'(1);
            edge_cnt_d = '0;
            ovf_next_d = 1'b0;
          end
        end
        ST_GATE: begin
          if (osc_rise_c) begin
            if (edge_cnt_q == {CNT_W{1'b1}}) begin
              ovf_next_d = 1'b1;
            end else begin
              edge_cnt_d = edge_cnt_q + CNT_W'(1);
            end
          end
          if (gate_cnt_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            gate_cnt_d = gate_cnt_q - GATE_W'(1);
          end
        end
        ST_LATCH: begin
          result_d = edge_cnt_q;
          ovf_d    = ovf_next_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_GATE);
  end

  assign res_ext_c = READ_W'(result_q);
  assign status_c  = pack_status(ovf_q, busy_q, state_q);

  // Readout mux; upper byte is zero-extended when CNT_W < 24.
  always_comb begin
    result_byte = '0;
    case (sel)
      SEL_LO:     result_byte = res_ext_c[7:0];
      SEL_MID:    result_byte = res_ext_c[15:8];
      SEL_HI:     result_byte = res_ext_c[23:16];
      SEL_STATUS: result_byte = status_c;
      default:    result_byte = '0;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Directed bench: a 9-bit counter for normal measurements and a 4-bit one driven hard into saturation.
`timescale 1ns/1ps
module tb_ring_osc_freq_counter;

  localparam int RUN_CYC = 250;

  typedef struct {
    int         half_ns;
    bit         hold;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    logic [7:0] exp_b2;
    logic [7:0] exp_st;
  } meas_vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       osc_a = 1'b0;
  logic       osc_b = 1'b0;
  int         half_a = 0;

  logic [7:0] byte_a, byte_b;
  logic       busy_a, done_a, ovf_a;
  logic       busy_b, done_b, ovf_b;

  int n_cmp = 0;
  int n_fail = 0;

  ring_osc_freq_counter #(.GATE_CYCLES(24'd100), .CNT_W(9)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_a), .start(start), .sel(sel),
    .result_byte(byte_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
  );

  ring_osc_freq_counter #(.GATE_CYCLES(24'd100), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_b), .start(start), .sel(sel),
    .result_byte(byte_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  // Oscillator edges sit 2ns off the clk grid so they never race a clk edge.
  initial begin
    #2;
    forever begin
      if (half_a == 0) begin
        osc_a = 1'b0;
        #10;
      end else begin
        #(half_a);
        osc_a = ~osc_a;
      end
    end
  end

  initial begin
    #2;
    forever begin
      #12.5;
      osc_b = ~osc_b;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_meas(input bit hold, input int repulse_at, input int ena_low_at,
                          output int busy_n, output int done_n, output int done_at);
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= RUN_CYC; c++) begin
      @(negedge clk);
      if (busy_a) busy_n++;
      if (done_a) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      start = hold || (c == repulse_at);
      if (c == ena_low_at) ena = 1'b0;
    end
    start = 1'b0;
    ena   = 1'b1;
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  meas_vec_t  vecs[4];
  logic [7:0] exp_a[4];
  logic [7:0] exp_b[4];
  int busy_n, done_n, done_at;

  initial begin
    vecs[0] = '{half_ns: 20, hold: 1'b0, exp_b0: 8'h19, exp_b1: 8'h00, exp_b2: 8'h00, exp_st: 8'h00};
    vecs[1] = '{half_ns: 25, hold: 1'b0, exp_b0: 8'h14, exp_b1: 8'h00, exp_b2: 8'h00, exp_st: 8'h00};
    vecs[2] = '{half_ns: 50, hold: 1'b0, exp_b0: 8'h0A, exp_b1: 8'h00, exp_b2: 8'h00, exp_st: 8'h00};
    vecs[3] = '{half_ns: 0,  hold: 1'b1, exp_b0: 8'h00, exp_b1: 8'h00, exp_b2: 8'h00, exp_st: 8'h00};
    exp_b[0] = 8'h0F; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h80;

    #1 rst_n = 1'b0;
    #20;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("rst_byte_a_sel%0d", s), int'(byte_a), 0);
      chk($sformatf("rst_byte_b_sel%0d", s), int'(byte_b), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      half_a = vecs[i].half_ns;
      settle();
      run_meas(vecs[i].hold, -1, -1, busy_n, done_n, done_at);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, 100);
      chk($sformatf("v%0d_done_count", i), done_n, 1);
      chk($sformatf("v%0d_done_cycle", i), done_at, 102);
      chk($sformatf("v%0d_ovf_a", i), int'(ovf_a), 0);
      chk($sformatf("v%0d_ovf_b", i), int'(ovf_b), 1);
      exp_a[0] = vecs[i].exp_b0; exp_a[1] = vecs[i].exp_b1;
      exp_a[2] = vecs[i].exp_b2; exp_a[3] = vecs[i].exp_st;
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        #1;
        chk($sformatf("v%0d_byte_a_sel%0d", i, s), int'(byte_a), int'(exp_a[s]));
        chk($sformatf("v%0d_byte_b_sel%0d", i, s), int'(byte_b), int'(exp_b[s]));
      end
    end

    // start re-pulsed mid-window must not restart or extend the measurement
    half_a = 20;
    settle();
    run_meas(1'b0, 50, -1, busy_n, done_n, done_at);
    chk("repulse_busy_cycles", busy_n, 100);
    chk("repulse_done_count", done_n, 1);
    chk("repulse_done_cycle", done_at, 102);
    sel = 2'd0;
    #1;
    chk("repulse_result", int'(byte_a), 25);

    // ena dropped at cycle 40: abort, no done, previous result kept
    half_a = 50;
    settle();
    run_meas(1'b0, -1, 40, busy_n, done_n, done_at);
    chk("ena_busy_cycles", busy_n, 40);
    chk("ena_done_count", done_n, 0);
    sel = 2'd0;
    #1;
    chk("ena_result_kept", int'(byte_a), 25);
    sel = 2'd3;
    #1;
    chk("ena_status_a", int'(byte_a), 8'h00);
    chk("ena_status_b", int'(byte_b), 8'h80);

    // async reset in the middle of a window clears everything at once
    half_a = 20;
    settle();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    sel = 2'd3;
    #1;
    chk("gate_status_a", int'(byte_a), 8'h50);
    chk("gate_status_b", int'(byte_b), 8'hD0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_done", int'(done_a), 0);
    chk("midrst_ovf_b", int'(ovf_b), 0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("midrst_byte_a_sel%0d", s), int'(byte_a), 0);
      chk($sformatf("midrst_byte_b_sel%0d", s), int'(byte_b), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run_meas(1'b0, -1, -1, busy_n, done_n, done_at);
    chk("recover_busy_cycles", busy_n, 100);
    chk("recover_done_count", done_n, 1);
    sel = 2'd0;
    #1;
    chk("recover_result", int'(byte_a), 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
